useq_ret_stack: RTL

//  Microsequencer call/return stack. Pushes the CROM address on a microcode

---
 rtl/useq_pkg.sv | 21 ++
 rtl/useq_ret_stack_ram.sv | 48 ++++
 rtl/useq_ret_stack.sv | 134 +++++++++++++
 3 files changed

// File: rtl/useq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : useq_pkg
// Brief   : Shared microsequencer constants: CROM address width, RETURN
//           dispatch codes and the page-fail trap vector.
// Revision: 1.0 - initial release
// ============================================================================
package useq_pkg;

  // Width of a CROM (control store) address.
  localparam int unsigned CROM_AW = 12;

  // DISP field codes that select dispRET as the next microaddress.
  localparam logic [5:0] DISP_RET0 = 6'o01;
  localparam logic [5:0] DISP_RET1 = 6'o41;

  // Microaddress forced on a page-fail trap.
  localparam logic [CROM_AW-1:0] PAGE_FAIL_VEC = 12'o7777;

endpackage : useq_pkg
`default_nettype wire

// File: rtl/useq_ret_stack_ram.sv
`default_nettype none
// ============================================================================
// Module  : useq_ret_stack_ram
// Brief   : DEPTH x AW register file, one synchronous write port and one
//           asynchronous read port. Contents are not reset.
// Revision: 1.0 - initial release
// ============================================================================
module useq_ret_stack_ram
  import useq_pkg::*;
#(
  parameter int unsigned AW    = CROM_AW,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] rd_vec [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic [AW-1:0] entry_d;
    logic [AW-1:0] entry_q;

    // Load this entry when it is the write target, otherwise keep it.
    always_comb begin
      entry_d = entry_q;
      if (we && (waddr == PW'(i))) begin
        entry_d = wdata;
      end
    end

    // Entry storage; deliberately left out of reset.
    always_ff @(posedge clk) begin
      entry_q <= entry_d;
    end

    assign rd_vec[i] = entry_q;
  end

  assign rdata = rd_vec[raddr];

endmodule : useq_ret_stack_ram
`default_nettype wire

// File: rtl/useq_ret_stack.sv
`default_nettype none
// ============================================================================
// Module  : useq_ret_stack
// Brief   : Microsequencer call/return stack. Pushes the CROM address on
//           CALL / page-fail, presents top-of-stack as dispRET, and keeps
//           sticky overflow/underflow flags plus an occupancy count.
// Revision: 1.0 - initial release
// ============================================================================
module useq_ret_stack
  import useq_pkg::*;
#(
  parameter int unsigned AW    = CROM_AW,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clken,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] addrIN,
  input  logic          clrERR,
  output logic [AW-1:0] addrOUT,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] sp_d, sp_q;
  logic [CW-1:0] count_d, count_q;
  logic          overflow_d, overflow_q;
  logic          underflow_d, underflow_q;

  logic          wr_en;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] top_addr;
  logic [AW-1:0] top_data;
  logic          empty;
  logic          full;

  // sp points at the next free slot, so the top lives one below it.
  assign top_addr = sp_q - PW'(1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  useq_ret_stack_ram #(
    .AW    (AW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (addrIN),
    .raddr (top_addr),
    .rdata (top_data)
  );

  // Next-state for pointer, occupancy and sticky flags plus the write strobe.
  always_comb begin
    sp_d        = sp_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    wr_en       = 1'b0;
    wr_addr     = sp_q;

    if (clken) begin
      // Clear first so that a set in the same cycle takes priority.
      if (clrERR) begin
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end

      unique case ({call, ret})
        2'b10: begin
          // Push; when full the ring overwrites the oldest entry.
          wr_en = 1'b1;
          sp_d  = sp_q + PW'(1);
          if (full) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
        2'b01: begin
          if (empty) begin
            underflow_d = 1'b1;
          end else begin
            sp_d    = sp_q - PW'(1);
            count_d = count_q - CW'(1);
          end
        end
        2'b11: begin
          if (empty) begin
            // Nothing to replace: behave as a push and flag the bad pop.
            wr_en       = 1'b1;
            sp_d        = sp_q + PW'(1);
            count_d     = count_q + CW'(1);
            underflow_d = 1'b1;
          end else begin
            wr_en   = 1'b1;
            wr_addr = top_addr;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers; asynchronous reset empties the stack immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign addrOUT   = empty ? '0 : top_data;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule : useq_ret_stack
`default_nettype wire
